// File: rtl/game_status_ctrl.sv
// Frame-level game referee: counts lives, grants post-hit invulnerability,
// keeps a saturating survival score and runs the IDLE/PLAY/DEAD/FINISHED machine.
module game_status_ctrl #(
  parameter int N_OBST        = 4,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int GOAL_FRAMES   = 3600
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_v_sync,
  input  logic              i_penguin_hit,
  input  logic [N_OBST-1:0] i_obstacle_hit,
  input  logic [N_OBST-1:0] i_crushed,
  input  logic              i_start,
  output logic [1:0]        o_state,
  output logic              o_is_dead,
  output logic              o_is_finished,
  output logic [2:0]        o_lives,
  output logic [15:0]       o_score,
  output logic              o_flash
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    DEAD     = 2'd2,
    FINISHED = 2'd3
  } state_t;

  localparam logic [2:0]  LIVES_INIT  = 3'(LIVES);
  localparam logic [7:0]  INVULN_INIT = 8'(INVULN_FRAMES);
  localparam logic [15:0] GOAL        = 16'(GOAL_FRAMES);

  state_t      state;
  logic        vs_q;
  logic        st_q;
  logic        hit_flag;
  logic        crush_flag;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [7:0]  invuln;

  logic        vs_rise;
  logic        st_rise;
  logic        hit_term;
  logic        crush_term;
  logic        hit_now;
  logic        fatal;
  logic [15:0] score_inc;
  logic        goal_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign vs_rise    = i_v_sync & ~vs_q;
  assign st_rise    = i_start & ~st_q;
  assign hit_term   = i_penguin_hit & (|i_obstacle_hit);
  assign crush_term = |i_crushed;

  // Frame verdict uses only the flags accumulated over the frame just ended.
  always_comb begin
    hit_now   = (hit_flag | crush_flag) && (invuln == 8'd0);
    fatal     = hit_now && (lives == 3'd1);
    score_inc = sat_inc(score);
    goal_hit  = (score_inc >= GOAL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      vs_q       <= 1'b0;
      st_q       <= 1'b0;
      hit_flag   <= 1'b0;
      crush_flag <= 1'b0;
      lives      <= 3'd0;
      score      <= 16'd0;
      invuln     <= 8'd0;
    end else begin
      vs_q <= i_v_sync;
      st_q <= i_start;

      // A tick restarts accumulation with this cycle's pixel instead of OR-ing.
      if (state == PLAY) begin
        hit_flag   <= vs_rise ? hit_term   : (hit_flag   | hit_term);
        crush_flag <= vs_rise ? crush_term : (crush_flag | crush_term);
      end else begin
        hit_flag   <= 1'b0;
        crush_flag <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (st_rise) begin
            state  <= PLAY;
            lives  <= LIVES_INIT;
            score  <= 16'd0;
            invuln <= 8'd0;
          end
        end
        PLAY: begin
          if (vs_rise) begin
            if (fatal) begin
              lives <= 3'd0;
              state <= DEAD;
            end else begin
              if (hit_now) begin
                lives  <= lives - 3'd1;
                invuln <= INVULN_INIT;
              end else if (invuln != 8'd0) begin
                invuln <= invuln - 8'd1;
              end
              score <= score_inc;
              if (goal_hit) state <= FINISHED;
            end
          end
        end
        DEAD, FINISHED: begin
          if (st_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_state       = state;
  assign o_is_dead     = (state == DEAD);
  assign o_is_finished = (state == IDLE) || (state == FINISHED);
  assign o_lives       = lives;
  assign o_score       = score;
  assign o_flash       = (invuln != 8'd0) & invuln[2];

endmodule

// File: tb/tb_game_status_ctrl.sv
// Directed bench for game_status_ctrl: a short-goal instance driven from a
// vector table, and a default instance driven by hand-written sequences.
module tb_game_status_ctrl;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic       v_sync = 1'b0;
  logic       ph = 1'b0;
  logic [3:0] oh = 4'd0;
  logic [3:0] cr = 4'd0;
  logic       start = 1'b0;

  logic [1:0]  state_a, state_b;
  logic        dead_a, dead_b, fin_a, fin_b, flash_a, flash_b;
  logic [2:0]  lives_a, lives_b;
  logic [15:0] score_a, score_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_status_ctrl dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_v_sync(v_sync), .i_penguin_hit(ph),
    .i_obstacle_hit(oh), .i_crushed(cr), .i_start(start),
    .o_state(state_a), .o_is_dead(dead_a), .o_is_finished(fin_a),
    .o_lives(lives_a), .o_score(score_a), .o_flash(flash_a)
  );

  game_status_ctrl #(.GOAL_FRAMES(5), .INVULN_FRAMES(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_v_sync(v_sync), .i_penguin_hit(ph),
    .i_obstacle_hit(oh), .i_crushed(cr), .i_start(start),
    .o_state(state_b), .o_is_dead(dead_b), .o_is_finished(fin_b),
    .o_lives(lives_b), .o_score(score_b), .o_flash(flash_b)
  );

  typedef struct {
    logic st_pulse;
    logic hit;
    logic crush;
    int   st;
    int   lives;
    int   score;
    int   dead;
    int   fin;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    v_sync = 1'b0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
  endtask

  task automatic do_frame(input logic hit, input logic crush);
    v_sync = 1'b0;
    step();
    if (hit) begin
      ph = 1'b1;
      oh = 4'b0010;
    end
    if (crush) cr = 4'b1000;
    step();
    ph = 1'b0;
    oh = 4'd0;
    cr = 4'd0;
    step();
    v_sync = 1'b1;
    step();
    step();
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, " state"},  int'(state_a), 0);
    chk({tag, " dead"},   int'(dead_a),  0);
    chk({tag, " fin"},    int'(fin_a),   1);
    chk({tag, " lives"},  int'(lives_a), 0);
    chk({tag, " score"},  int'(score_a), 0);
    chk({tag, " flash"},  int'(flash_a), 0);
  endtask

  initial begin
    int inv;
    int exp_score;

    //          start hit crush st lives score dead fin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, 3, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1, 3, 1, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1, 3, 2, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1, 3, 3, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1, 3, 4, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 3, 3, 5, 0, 1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 3, 3, 5, 0, 1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 0, 3, 5, 0, 1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1, 3, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1, 2, 1, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1, 2, 2, 0, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1, 1, 3, 0, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1, 1, 4, 0, 0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 2, 0, 4, 1, 0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 0, 0, 4, 0, 1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1, 3, 0, 0, 0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1, 3, 0, 0, 0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1, 3, 1, 0, 0};

    step();
    step();
    rst_b = 1'b1;
    step();
    chk("b reset state", int'(state_b), 0);
    chk("b reset fin",   int'(fin_b),   1);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].st_pulse) do_start();
      else                 do_frame(tbl[i].hit, tbl[i].crush);
      chk($sformatf("b[%0d] state", i), int'(state_b), tbl[i].st);
      chk($sformatf("b[%0d] lives", i), int'(lives_b), tbl[i].lives);
      chk($sformatf("b[%0d] score", i), int'(score_b), tbl[i].score);
      chk($sformatf("b[%0d] dead",  i), int'(dead_b),  tbl[i].dead);
      chk($sformatf("b[%0d] fin",   i), int'(fin_b),   tbl[i].fin);
      chk($sformatf("b[%0d] flash", i), int'(flash_b), 0);
    end
    rst_b = 1'b0;

    // Default instance: reset, start latency, long invulnerability window
    step();
    rst_a = 1'b1;
    step();
    chk_reset_a("a reset");

    start = 1'b1;
    step();
    chk("a start state", int'(state_a), 1);
    chk("a start lives", int'(lives_a), 3);
    chk("a start score", int'(score_a), 0);
    chk("a start fin",   int'(fin_a),   0);
    start = 1'b0;
    step();

    do_frame(1'b1, 1'b0);
    exp_score = 1;
    inv = 60;
    chk("a hit1 lives", int'(lives_a), 2);
    chk("a hit1 flash", int'(flash_a), 1);
    chk("a hit1 score", int'(score_a), exp_score);

    for (int k = 1; k <= 59; k++) begin
      do_frame(1'b1, 1'b0);
      inv--;
      exp_score++;
      chk($sformatf("a immune%0d lives", k), int'(lives_a), 2);
      chk($sformatf("a immune%0d flash", k), int'(flash_a), ((inv & 4) != 0) ? 1 : 0);
    end

    do_frame(1'b0, 1'b0);
    exp_score++;
    chk("a f60 lives", int'(lives_a), 2);
    chk("a f60 flash", int'(flash_a), 0);

    do_frame(1'b1, 1'b0);
    exp_score++;
    chk("a f61 lives", int'(lives_a), 1);
    chk("a f61 flash", int'(flash_a), 1);
    chk("a f61 score", int'(score_a), exp_score);
    chk("a f61 state", int'(state_a), 1);

    // Asynchronous reset in the middle of a cycle, during invulnerability
    v_sync = 1'b0;
    step();
    #2;
    rst_a = 1'b0;
    #1;
    chk_reset_a("a midreset");

    v_sync = 1'b1;
    step();
    step();
    rst_a = 1'b1;
    step();
    step();
    chk("a post-rst state", int'(state_a), 0);
    chk("a post-rst score", int'(score_a), 0);

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("a vs-held state", int'(state_a), 1);
    chk("a vs-held score", int'(score_a), 0);
    chk("a vs-held lives", int'(lives_a), 3);

    v_sync = 1'b0;
    step();
    v_sync = 1'b1;
    step();
    chk("a tick score", int'(score_a), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
